// File: rtl/bcd_timer_multi_pkg.sv
// Shared definitions for the BCD countdown/stopwatch timer.
//   timer_state_t : FSM states (IDLE, RUN, PAUSE, DONE)
//   BCD_MAX9/5    : per-digit maximum values
//   digit_max()   : maximum value for a digit index under the chosen radix
package bcd_timer_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    localparam logic [3:0] BCD_MAX9 = 4'd9;
    localparam logic [3:0] BCD_MAX5 = 4'd5;

    // Digits 1 and 3 are the tens of seconds / tens of minutes in min:sec mode.
    function automatic logic [3:0] digit_max(input int unsigned idx, input bit sexagesimal);
        return (sexagesimal && (idx == 1 || idx == 3)) ? BCD_MAX5 : BCD_MAX9;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the timer.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear to zero (highest priority)
//   edit_inc/_dec : single-cycle edit requests, wrap within the digit, cancel if both
//   step_en    : count step in progress; digit moves only when cin is also high
//   dir_up     : 1 = increment/carry, 0 = decrement/borrow
//   cin, cout  : ripple carry (up) or borrow (down)
//   max        : largest legal value of this digit (9 or 5)
//   digit      : current value; at_zero / at_max flag the two extremes
module bcd_digit_cell (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       edit_inc,
    input  logic       edit_dec,
    input  logic       step_en,
    input  logic       dir_up,
    input  logic       cin,
    input  logic [3:0] max,
    output logic [3:0] digit,
    output logic       cout,
    output logic       at_zero,
    output logic       at_max
);

    assign at_zero = (digit == '0);
    assign at_max  = (digit == max);
    // Carry/borrow ripples through regardless of step_en so the chain's
    // far end also tells the top level whether the value is already terminal.
    assign cout    = cin & (dir_up ? at_max : at_zero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (step_en && cin) begin
            if (dir_up)
                digit <= at_max ? '0 : digit + 4'd1;
            else
                digit <= at_zero ? max : digit - 4'd1;
        end else if (edit_inc && !edit_dec) begin
            digit <= at_max ? '0 : digit + 4'd1;
        end else if (edit_dec && !edit_inc) begin
            digit <= at_zero ? max : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_timer_multi.sv
// Digit-editable BCD countdown timer / stopwatch driving a 7-seg data bus.
//   Clk, Reset          : clock, asynchronous active-high reset
//   cnt_inc, cnt_dec    : per-digit edit levels (rising edge = one edit)
//   mode_up             : 0 = count down to zero, 1 = count up to full scale
//   start_flag          : start (IDLE), resume (PAUSE), acknowledge (DONE)
//   pause_flag          : RUN -> PAUSE
//   reset_flag          : synchronous clear to zero / IDLE
//   Data                : BCD value, digit 0 in [3:0]
//   running             : high in RUN
//   done_pulse, alarm   : expiry strobe and latched expiry flag
module bcd_timer_multi
    import bcd_timer_multi_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int TICK_DIV    = 50_000_000,
    parameter int SEXAGESIMAL = 0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_DIGITS-1:0]   cnt_inc,
    input  logic [NUM_DIGITS-1:0]   cnt_dec,
    input  logic                    mode_up,
    input  logic                    start_flag,
    input  logic                    pause_flag,
    input  logic                    reset_flag,
    output logic [4*NUM_DIGITS-1:0] Data,
    output logic                    running,
    output logic                    done_pulse,
    output logic                    alarm
);

    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]     DIGIT0_MAX = digit_max(0, SEXAGESIMAL != 0);

    timer_state_t          state;
    logic [PW-1:0]         presc;
    logic                  dir_up;
    logic [NUM_DIGITS-1:0] inc_q, dec_q, inc_edge, dec_edge;
    logic [NUM_DIGITS-1:0] at_zero, at_max;
    logic [NUM_DIGITS:0]   chain;
    logic                  edit_ok, strobe, step_en;
    logic                  terminal_now, terminal_next, expire;
    logic                  rest_zero, rest_max, start_ok;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            inc_q <= '0;
            dec_q <= '0;
        end else begin
            inc_q <= cnt_inc;
            dec_q <= cnt_dec;
        end
    end

    assign edit_ok  = (state == ST_IDLE) || (state == ST_PAUSE);
    assign inc_edge = cnt_inc & ~inc_q & {NUM_DIGITS{edit_ok}};
    assign dec_edge = cnt_dec & ~dec_q & {NUM_DIGITS{edit_ok}};

    assign strobe   = (state == ST_RUN) && !reset_flag && !pause_flag && (presc == PRESC_LAST);
    assign chain[0] = 1'b1;

    // With cin tied high at digit 0, the end of the ripple chain is set
    // exactly when every digit is already at the terminal value.
    assign terminal_now = chain[NUM_DIGITS];
    assign step_en      = strobe && !terminal_now;

    // Expiry must be known before the step lands so done_pulse/alarm rise
    // on the same edge as Data reaches the terminal value.
    always_comb begin
        rest_zero = 1'b1;
        rest_max  = 1'b1;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            rest_zero &= at_zero[i];
            rest_max  &= at_max[i];
        end
        terminal_next = dir_up ? (rest_max  && Data[3:0] == DIGIT0_MAX - 4'd1)
                               : (rest_zero && Data[3:0] == 4'd1);
    end

    assign expire   = strobe && (terminal_now || terminal_next);
    assign start_ok = mode_up || !(&at_zero);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk      (Clk),
            .rst      (Reset),
            .clr      (reset_flag),
            .edit_inc (inc_edge[g]),
            .edit_dec (dec_edge[g]),
            .step_en  (step_en),
            .dir_up   (dir_up),
            .cin      (chain[g]),
            .max      (digit_max(g, SEXAGESIMAL != 0)),
            .digit    (Data[4*g +: 4]),
            .cout     (chain[g+1]),
            .at_zero  (at_zero[g]),
            .at_max   (at_max[g])
        );
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            presc      <= '0;
            dir_up     <= 1'b0;
            running    <= 1'b0;
            done_pulse <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (reset_flag) begin
                state   <= ST_IDLE;
                presc   <= '0;
                running <= 1'b0;
                alarm   <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (!pause_flag && start_flag && start_ok) begin
                            state   <= ST_RUN;
                            presc   <= '0;
                            dir_up  <= mode_up;
                            running <= 1'b1;
                            alarm   <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (pause_flag) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end else if (strobe) begin
                            presc <= '0;
                            if (expire) begin
                                state      <= ST_DONE;
                                running    <= 1'b0;
                                done_pulse <= 1'b1;
                                alarm      <= 1'b1;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (!pause_flag && start_flag) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (!pause_flag && start_flag) begin
                            state <= ST_IDLE;
                            alarm <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_timer_multi.sv
// Directed bench for bcd_timer_multi: a decimal instance and a min:sec
// instance driven by the same stimulus.
module tb_bcd_timer_multi;

    logic        Clk, Reset;
    logic [7:0]  cnt_inc, cnt_dec;
    logic        mode_up, start_flag, pause_flag, reset_flag;
    logic [31:0] data, data_s;
    logic        running, done_pulse, alarm;
    logic        running_s, done_s, alarm_s;

    int tests = 0;
    int fails = 0;

    bcd_timer_multi #(.NUM_DIGITS(8), .TICK_DIV(4), .SEXAGESIMAL(0)) u_dut (
        .Clk(Clk), .Reset(Reset), .cnt_inc(cnt_inc), .cnt_dec(cnt_dec),
        .mode_up(mode_up), .start_flag(start_flag), .pause_flag(pause_flag),
        .reset_flag(reset_flag), .Data(data), .running(running),
        .done_pulse(done_pulse), .alarm(alarm)
    );

    bcd_timer_multi #(.NUM_DIGITS(8), .TICK_DIV(4), .SEXAGESIMAL(1)) u_dut_sex (
        .Clk(Clk), .Reset(Reset), .cnt_inc(cnt_inc), .cnt_dec(cnt_dec),
        .mode_up(mode_up), .start_flag(start_flag), .pause_flag(pause_flag),
        .reset_flag(reset_flag), .Data(data_s), .running(running_s),
        .done_pulse(done_s), .alarm(alarm_s)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic edit(input logic [7:0] im, input logic [7:0] dm);
        cnt_inc = im;
        cnt_dec = dm;
        tick();
        cnt_inc = '0;
        cnt_dec = '0;
        tick();
    endtask

    task automatic pulse_start;
        start_flag = 1'b1;
        tick();
        start_flag = 1'b0;
    endtask

    task automatic pulse_clear;
        reset_flag = 1'b1;
        tick();
        reset_flag = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; cnt_inc = '0; cnt_dec = '0;
        mode_up = 1'b0; start_flag = 1'b0; pause_flag = 1'b0; reset_flag = 1'b0;
        ticks(2);
        Reset = 1'b0;
        tick();
        chk("rst_data", data, 32'h0);
        chk("rst_running", {31'b0, running}, 32'h0);
        chk("rst_alarm", {31'b0, alarm}, 32'h0);
        chk("rst_done", {31'b0, done_pulse}, 32'h0);

        // Edits
        repeat (3) edit(8'h01, 8'h00);
        repeat (2) edit(8'h02, 8'h00);
        chk("edit_inc", data, 32'h0000_0023);
        repeat (4) edit(8'h00, 8'h01);
        chk("edit_dec_wrap", data, 32'h0000_0029);
        cnt_inc = 8'h01;
        ticks(10);
        cnt_inc = '0;
        tick();
        chk("edit_hold", data, 32'h0000_0020);
        edit(8'h02, 8'h02);
        chk("edit_cancel", data, 32'h0000_0020);
        edit(8'h03, 8'h00);
        chk("edit_multi", data, 32'h0000_0031);
        pulse_clear();
        chk("clear_data", data, 32'h0);

        // Countdown from 10
        edit(8'h02, 8'h00);
        chk("preset10", data, 32'h10);
        mode_up = 1'b0;
        pulse_start();
        chk("run_running", {31'b0, running}, 32'h1);
        ticks(3);
        chk("before_step", data, 32'h10);
        tick();
        chk("first_step", data, 32'h09);
        ticks(35);
        chk("step9", data, 32'h01);
        chk("no_early_done", {31'b0, done_pulse}, 32'h0);
        tick();
        chk("expire_data", data, 32'h00);
        chk("expire_done", {31'b0, done_pulse}, 32'h1);
        chk("expire_alarm", {31'b0, alarm}, 32'h1);
        chk("expire_running", {31'b0, running}, 32'h0);
        tick();
        chk("done_one_cycle", {31'b0, done_pulse}, 32'h0);
        chk("alarm_latched", {31'b0, alarm}, 32'h1);
        edit(8'h01, 8'h00);
        chk("done_edit_ignored", data, 32'h00);
        pulse_start();
        chk("ack_alarm", {31'b0, alarm}, 32'h0);

        // Start at zero in down mode is refused
        pulse_start();
        chk("zero_start", {31'b0, running}, 32'h0);
        edit(8'h01, 8'h00);
        chk("zero_start_idle", data, 32'h01);
        pulse_clear();

        // Radix: 0100 counts down to 0099 / 0059
        edit(8'h04, 8'h00);
        pulse_start();
        ticks(4);
        chk("dec_borrow", data, 32'h0000_0099);
        chk("sex_borrow", data_s, 32'h0000_0059);
        pulse_clear();
        chk("runclear_data", data, 32'h0);
        chk("runclear_running", {31'b0, running}, 32'h0);
        chk("runclear_running_s", {31'b0, running_s}, 32'h0);

        // Pause mid-period, edit, resume at preserved phase
        repeat (5) edit(8'h01, 8'h00);
        pulse_start();
        ticks(4);
        chk("p_step1", data, 32'h04);
        ticks(4);
        chk("p_step2", data, 32'h03);
        ticks(2);
        pause_flag = 1'b1;
        tick();
        pause_flag = 1'b0;
        chk("paused_running", {31'b0, running}, 32'h0);
        ticks(20);
        chk("paused_hold", data, 32'h03);
        edit(8'h02, 8'h00);
        chk("paused_edit", data, 32'h13);
        pulse_start();
        tick();
        chk("resume_wait", data, 32'h13);
        tick();
        chk("resume_phase", data, 32'h12);
        pulse_clear();
        chk("pclear_data", data, 32'h0);
        chk("pclear_running", {31'b0, running}, 32'h0);

        // Asynchronous reset mid-run
        edit(8'h01, 8'h00);
        pulse_start();
        ticks(2);
        chk("pre_areset_running", {31'b0, running}, 32'h1);
        #3 Reset = 1'b1;
        #1;
        chk("areset_data", data, 32'h0);
        chk("areset_running", {31'b0, running}, 32'h0);
        chk("areset_alarm", {31'b0, alarm}, 32'h0);
        tick();
        Reset = 1'b0;
        tick();

        // Up mode to full scale
        edit(8'h00, 8'hFF);
        edit(8'h00, 8'h01);
        chk("up_preset", data, 32'h9999_9998);
        chk("up_preset_s", data_s, 32'h9999_5958);
        mode_up = 1'b1;
        pulse_start();
        ticks(3);
        chk("up_wait", data, 32'h9999_9998);
        chk("up_wait_done", {31'b0, done_pulse}, 32'h0);
        tick();
        chk("up_full", data, 32'h9999_9999);
        chk("up_done", {31'b0, done_pulse}, 32'h1);
        chk("up_alarm", {31'b0, alarm}, 32'h1);
        chk("up_running", {31'b0, running}, 32'h0);
        chk("up_full_s", data_s, 32'h9999_5959);
        chk("up_done_s", {31'b0, done_s}, 32'h1);
        tick();
        chk("up_done_once", {31'b0, done_pulse}, 32'h0);
        ticks(8);
        chk("up_no_wrap", data, 32'h9999_9999);
        pulse_start();
        chk("up_ack_alarm", {31'b0, alarm}, 32'h0);
        chk("up_ack_alarm_s", {31'b0, alarm_s}, 32'h0);
        chk("up_ack_data", data, 32'h9999_9999);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
